mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Two-requester arbiter and sequencer placed in front of the external memory interface (flash/SRAM/SDRAM/LED decode). It shares the single CPU-side memory port between the instruction-fetch port (I) and the load/store data port (D). It uses round-robin tie-breaking, one outstanding access at a time, and a bounded wait-state timeout. It converts the interface's level re/we/needWait protocol into a req/ack handshake per requester.

Parameters:
ADDR_W, 24, byte/word address width passed to the memory interface
DATA_W, 16, data word width
TIMEOUT, 255, max cycles needWait may stay high before the access is aborted (1..2^16-1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_req_i  in  1  I-port request, held until i_ack_o
i_addr_i  in  ADDR_W  I-port address (read-only port)
i_rdata_o  out  DATA_W  I-port read data, valid while i_ack_o=1
i_ack_o  out  1  I-port one-cycle completion pulse
i_err_o  out  1  I-port timeout flag, valid with i_ack_o
d_req_i  in  1  D-port request, held until d_ack_o
d_we_i  in  1  D-port 1=write 0=read
d_addr_i  in  ADDR_W  D-port address
d_wdata_i  in  DATA_W  D-port write data
d_rdata_o  out  DATA_W  D-port read data, valid while d_ack_o=1
d_ack_o  out  1  D-port one-cycle completion pulse
d_err_o  out  1  D-port timeout flag, valid with d_ack_o
mem_addr_o  out  ADDR_W  to interface addr_i
mem_data_io  inout  DATA_W  to interface data_io_cpu
mem_re_o  out  1  to interface re_i
mem_we_o  out  1  to interface we_i
mem_needWait_i  in  1  from interface needWait_o

Behaviour:
- Clock and reset are fixed: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values (immediate on rst_n=0): state=IDLE; mem_re_o=0; mem_we_o=0; mem_addr_o=0; mem_data_io=Z; all ack/err=0; rdata regs=0; last_grant=D; wait counter=0.
- FSM states: IDLE, ACCESS, ACK.
- IDLE -> ACCESS:
  - Only one of i_req_i/d_req_i high: grant that port.
  - Both high: grant the port not equal to last_grant. After reset this means I wins the first tie.
  - On the transition, register addr, we (forced 0 for I), wdata and owner. Update last_grant to owner.
- ACCESS:
  - mem_addr_o = registered addr.
  - mem_re_o = ~we; mem_we_o = we.
  - mem_data_io driven with registered wdata only when we=1, else Z.
  - All four stay stable for the whole state.
  - Wait counter increments each cycle mem_needWait_i=1.
- ACCESS exit on a clock edge where mem_needWait_i=0:
  - Capture mem_data_io into the owner's rdata register (reads only; writes leave it unchanged).
  - err=0; go to ACK.
- ACCESS exit when mem_needWait_i=1 and counter==TIMEOUT-1:
  - Abort, owner rdata=0, err=1, go to ACK.
- ACK (one cycle):
  - mem_re_o/mem_we_o=0, bus Z.
  - Owner's ack_o=1 with rdata/err valid.
  - Counter cleared. Next state IDLE.
  - req inputs are ignored in ACK.
  - The requester drops req in the ACK cycle unless it issues a new request; a req still high in the following IDLE is a new request.
- Latency: req seen high at edge N -> ACCESS cycle N+1 -> ack cycle N+2+W, where W = wait cycles. Zero-wait throughput is one access per 3 cycles.
- Requests are not pre-emptible. A request arriving during ACCESS/ACK waits; the tie-breaker is evaluated only in IDLE.
- Requester inputs changing while not granted have no effect. Inputs of the owner are not re-sampled after grant.
- Reset asserted mid-ACCESS: bus released and strobes dropped asynchronously; no ack is issued for the aborted access.
- Never assert mem_re_o and mem_we_o together. The non-owner's ack is always 0.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum arb_state_t {IDLE, ACCESS, ACK}
  - typedef enum arb_port_t {PORT_I, PORT_D}
  - localparam defaults for ADDR_W/DATA_W
- One sub-module, mem_rr_pick (combinational): inputs i_req, d_req, last_grant; outputs valid and the winning arb_port_t.
- Everything else stays in mem_port_arbiter.

Test Plan:
- I read at 0x000010 alone, needWait=0, memory returns 16'hBEEF:
  - mem_re_o=1 for exactly 1 cycle.
  - i_ack_o pulses 2 cycles after req with i_rdata_o=16'hBEEF, i_err_o=0.
- I and D requests asserted in the same cycle after reset:
  - I granted first, D second (D write 16'h1234 to 0x400004).
  - mem_data_io=16'h1234 only during D ACCESS; ack order I then D.
- D write to 0x480000 with needWait high for 3 cycles:
  - mem_we_o high 4 cycles, addr/data stable throughout.
  - d_ack_o on the cycle after needWait falls; d_rdata_o unchanged.
- Both reqs held continuously for 6 accesses:
  - Grants alternate I,D,I,D,I,D.
  - No cycle with both strobes high.
- D read with needWait stuck high, TIMEOUT=8:
  - mem_re_o high exactly 8 cycles.
  - d_ack_o=1, d_err_o=1, d_rdata_o=0; next I request served normally.
- rst_n pulsed low during the 2nd wait cycle of an I read:
  - Strobes drop and bus goes Z within the reset cycle, no i_ack_o.
  - After release, the next tie goes to I.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and default widths for the two-port memory
//                arbiter (instruction port I, load/store port D).
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

   localparam int MEM_ADDR_W_DEF = 24;
   localparam int MEM_DATA_W_DEF = 16;

   // Sequencer states: wait for a request, run one memory access, pulse ack
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      ACK    = 2'd2
   } arb_state_t;

   // Requester identity, also used as the round-robin history
   typedef enum logic {
      PORT_I = 1'b0,
      PORT_D = 1'b1
   } arb_port_t;

endpackage
`default_nettype wire

// File: rtl/mem_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : mem_rr_pick
//  Description : Combinational two-way round-robin pick. A lone request wins
//                outright; on a tie the port that was not granted last wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_rr_pick
   import mem_arb_pkg::*;
(
   input  logic      i_req_i,
   input  logic      d_req_i,
   input  arb_port_t last_grant_i,
   output logic      valid_o,
   output arb_port_t grant_o
);

   // Select the winner from the current request pair and grant history
   always_comb begin
      valid_o = i_req_i | d_req_i;
      grant_o = PORT_I;
      if (i_req_i && d_req_i) begin
         grant_o = (last_grant_i == PORT_I) ? PORT_D : PORT_I;
      end else if (d_req_i) begin
         grant_o = PORT_D;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one CPU-side memory port between the instruction
//                fetch port and the load/store port. One access in flight,
//                round-robin on ties, bounded needWait timeout, and a
//                req/ack handshake per requester.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = MEM_ADDR_W_DEF,
   parameter int DATA_W  = MEM_DATA_W_DEF,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req_i,
   input  logic [ADDR_W-1:0] i_addr_i,
   output logic [DATA_W-1:0] i_rdata_o,
   output logic              i_ack_o,
   output logic              i_err_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              d_ack_o,
   output logic              d_err_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   inout  wire  [DATA_W-1:0] mem_data_io,
   output logic              mem_re_o,
   output logic              mem_we_o,
   input  logic              mem_needWait_i
);

   localparam int               CNT_W        = 16;
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

   arb_state_t        state_q, state_d;
   arb_port_t         owner_q;          // current owner, doubles as last grant
   arb_port_t         pick_port;
   logic              pick_valid;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [DATA_W-1:0] wdata_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
   logic              err_q;
   logic              bus_oe;
   logic              grant_now;
   logic              done_now;
   logic              abort_now;

   mem_rr_pick u_pick (
      .i_req_i      (i_req_i),
      .d_req_i      (d_req_i),
      .last_grant_i (owner_q),
      .valid_o      (pick_valid),
      .grant_o      (pick_port)
   );

   assign grant_now = (state_q == IDLE) && pick_valid;
   assign done_now  = (state_q == ACCESS) && !mem_needWait_i;
   assign abort_now = (state_q == ACCESS) && mem_needWait_i && (cnt_q == TIMEOUT_LAST);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; requests are only looked at in IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pick_valid) state_d = ACCESS;
         ACCESS:  if (done_now || abort_now) state_d = ACK;
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode: strobes only in ACCESS, owner-only ack pulse in ACK
   always_comb begin
      mem_re_o = 1'b0;
      mem_we_o = 1'b0;
      bus_oe   = 1'b0;
      i_ack_o  = 1'b0;
      d_ack_o  = 1'b0;
      case (state_q)
         ACCESS: begin
            mem_re_o = ~we_q;
            mem_we_o = we_q;
            bus_oe   = we_q;
         end
         ACK: begin
            i_ack_o = (owner_q == PORT_I);
            d_ack_o = (owner_q == PORT_D);
         end
         default: ;
      endcase
   end

   // Latch the winner's request at grant; the owner is not re-sampled later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q <= PORT_D;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
      end else if (grant_now) begin
         owner_q <= pick_port;
         if (pick_port == PORT_I) begin
            addr_q <= i_addr_i;
            we_q   <= 1'b0;
         end else begin
            addr_q  <= d_addr_i;
            we_q    <= d_we_i;
            wdata_q <= d_wdata_i;
         end
      end
   end

   // Wait-state counter: counts needWait cycles of the current access only
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                    cnt_q <= '0;
      else if ((state_q == ACCESS) && mem_needWait_i) cnt_q <= cnt_q + 1'b1;
      else                                           cnt_q <= '0;
   end

   // Completion capture: read data on success, zero plus error on timeout
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         err_q     <= 1'b0;
      end else if (done_now) begin
         err_q <= 1'b0;
         if (!we_q) begin
            if (owner_q == PORT_I) i_rdata_q <= mem_data_io;
            else                   d_rdata_q <= mem_data_io;
         end
      end else if (abort_now) begin
         err_q <= 1'b1;
         if (owner_q == PORT_I) i_rdata_q <= '0;
         else                   d_rdata_q <= '0;
      end
   end

   assign mem_addr_o  = addr_q;
   assign mem_data_io = bus_oe ? wdata_q : {DATA_W{1'bz}};
   assign i_rdata_o   = i_rdata_q;
   assign d_rdata_o   = d_rdata_q;
   assign i_err_o     = i_ack_o & err_q;
   assign d_err_o     = d_ack_o & err_q;

endmodule
`default_nettype wire
